ahb_slave_mem: RTL

- Bus-side responder paired with the master data path and address decoder: a selected slave with a small word memory behind the shared 16-bit address / 32-bit data bus.
- Accepts pipelined address phases and returns read data, ready and response in the data phase.
- Supports programmable wait states and issues a two-cycle ERROR for illegal accesses.
- Instantiated once per slave slot. Its hsel_i comes from the decoder; its hrdata_o/hready_o/hresp_o feed the slave-return mux.

---
 rtl/ahb_slave_mem_pkg.sv | 38 +++
 rtl/ahb_slave_mem_array.sv | 36 +++
 rtl/ahb_slave_mem.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB definitions for the slave memory: transfer/response codes,
// bus widths, FSM state encoding and the slave-window legality check.
package ahb_slave_mem_pkg;

    localparam int unsigned HADDR_W = 16;
    localparam int unsigned HDATA_W = 32;
    localparam int unsigned WIN_W   = 13;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    // Illegal when misaligned or when any window bit above the word offset is set.
    function automatic logic addr_illegal(input logic [WIN_W-1:0] win, input int unsigned mem_aw);
        logic [WIN_W-1:0] hi;
        hi = win >> (mem_aw + 2);
        return (win[1:0] != 2'b00) || (hi != '0);
    endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word memory for the AHB slave: 2**AW x DW registers, async clear,
// one synchronous write port and one combinational read port.
//   clk, rst_n        : clock, async active-low clear of all words
//   we, waddr, wdata  : write port (captured on rising edge)
//   raddr, rdata_c    : combinational read port
module ahb_slave_mem_array #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Storage with whole-array clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB slave with a small word memory, programmable wait states and a
// two-cycle ERROR response for misaligned or out-of-window accesses.
//   clk, rst                 : bus clock, async active-low reset
//   hsel_i, haddr_i,
//   htrans_i, hwrite_i       : address phase from master/decoder
//   hready_i                 : bus-wide ready qualifying the address phase
//   hwdata_i                 : write data (data phase)
//   hrdata_o, hready_o,
//   hresp_o                  : data-phase response to the return mux
module ahb_slave_mem
    import ahb_slave_mem_pkg::*;
#(
    parameter int unsigned MEM_AW      = 4,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hsel_i,
    input  logic [HADDR_W-1:0] haddr_i,
    input  logic [1:0]         htrans_i,
    input  logic               hwrite_i,
    input  logic [HDATA_W-1:0] hwdata_i,
    input  logic               hready_i,
    output logic [HDATA_W-1:0] hrdata_o,
    output logic               hready_o,
    output logic [1:0]         hresp_o
);

    localparam int unsigned CNT_W = 3;

    state_e              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [MEM_AW-1:0]   offset, offset_next;
    logic                write_q, write_next;
    logic                accept_c, illegal_c, we_c;
    logic                ready_next;
    hresp_e              resp_next;
    logic [HDATA_W-1:0]  hrdata_next, mem_rdata_c;
    logic                unused_bits;

    // Upper address bits are decoded externally; htrans_i[0] only separates NONSEQ/SEQ.
    assign unused_bits = ^{haddr_i[HADDR_W-1:WIN_W], htrans_i[0]};

    assign accept_c  = hsel_i && htrans_i[1] && hready_i &&
                       (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
    assign illegal_c = addr_illegal(haddr_i[WIN_W-1:0], MEM_AW);
    assign we_c      = (state == ST_DATA) && write_q;

    ahb_slave_mem_array #(
        .AW (MEM_AW),
        .DW (HDATA_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst),
        .we      (we_c),
        .waddr   (offset),
        .wdata   (hwdata_i),
        .raddr   (offset_next),
        .rdata_c (mem_rdata_c)
    );

    // State, transfer context and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            offset   <= '0;
            write_q  <= 1'b0;
            hready_o <= 1'b1;
            hresp_o  <= HRESP_OKAY;
            hrdata_o <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            offset   <= offset_next;
            write_q  <= write_next;
            hready_o <= ready_next;
            hresp_o  <= resp_next;
            hrdata_o <= hrdata_next;
        end
    end

    // Next state; IDLE, DATA and ERR2 all share the accept rules.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        offset_next = offset;
        write_next  = write_q;
        unique case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_c) begin
                    offset_next = haddr_i[MEM_AW+1:2];
                    write_next  = hwrite_i;
                    if (illegal_c) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = ST_DATA;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    // Next output values, derived from the state being entered.
    always_comb begin
        ready_next  = 1'b1;
        resp_next   = HRESP_OKAY;
        hrdata_next = hrdata_o;
        unique case (state_next)
            ST_WAIT: ready_next = 1'b0;
            ST_ERR1: begin
                ready_next = 1'b0;
                resp_next  = HRESP_ERROR;
            end
            ST_ERR2: resp_next = HRESP_ERROR;
            default: ;
        endcase
        // Read data loads on entry to DATA; a same-edge write to that word is forwarded.
        if (state_next == ST_DATA && !write_next) begin
            hrdata_next = (we_c && offset == offset_next) ? hwdata_i : mem_rdata_c;
        end
    end

endmodule
